// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg -- shared definitions for the alu_pipe block.
//   op_e          : 4-bit operation select. The low half keeps the legacy
//                   3-bit ALU encoding with the MSB clear.
//   FLAG_*        : bit positions inside the 4-bit flags bus {ovf, carry, neg, zero}.
//   ILLEGAL_OP    : the single reserved opcode (forces y=0, op_err=1).
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_PASSA   = 4'b0000,
        OP_ADD     = 4'b0001,
        OP_SUB     = 4'b0010,
        OP_AND     = 4'b0011,
        OP_OR      = 4'b0100,
        OP_INCA    = 4'b0101,
        OP_DECA    = 4'b0110,
        OP_PASSB   = 4'b0111,
        OP_XOR     = 4'b1000,
        OP_SLL     = 4'b1001,
        OP_SRL     = 4'b1010,
        OP_SRA     = 4'b1011,
        OP_SLT     = 4'b1100,
        OP_SLTU    = 4'b1101,
        OP_NOTA    = 4'b1110,
        OP_ILLEGAL = 4'b1111
    } op_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

    localparam logic [3:0] ILLEGAL_OP = OP_ILLEGAL;

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core -- purely combinational operation, flag and saturation
// evaluation used in the second pipeline stage of alu_pipe.
// Optional feature: define ALU_PIPE_SAT_EN to clamp signed-overflowing
// ADD/SUB/INCA/DECA results to the signed max/min instead of wrapping.
// Ports:
//   op_code  in   4      operation select (alu_pipe_pkg::op_e encoding)
//   a, b     in   WIDTH  operands; shifts use b[SHW-1:0] only
//   y        out  WIDTH  result
//   flags    out  4      {ovf, carry, neg, zero} of the final y
//   op_err   out  1      op_code was the illegal opcode
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags,
    output logic             op_err
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_ovf;
    logic             sub_ovf;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;

    always_comb begin
        // INCA/DECA reuse the adder/subtractor with b forced to 1
        b_eff    = ((op_code == OP_INCA) || (op_code == OP_DECA)) ? WIDTH'(1) : b;
        sum_ext  = {1'b0, a} + {1'b0, b_eff};
        // the extra top bit of the extended difference is the unsigned borrow
        diff_ext = {1'b0, a} - {1'b0, b_eff};
        add_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1]  != a[WIDTH-1]);
        sub_ovf  = (a[WIDTH-1] != b_eff[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
        sh       = b[SHW-1:0];

        res    = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        op_err = 1'b0;

        case (op_code)
            OP_PASSA: res = a;
            OP_ADD, OP_INCA: begin
                res   = sum_ext[WIDTH-1:0];
                carry = sum_ext[WIDTH];
                ovf   = add_ovf;
            end
            OP_SUB, OP_DECA: begin
                res   = diff_ext[WIDTH-1:0];
                carry = diff_ext[WIDTH];
                ovf   = sub_ovf;
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_PASSB: res = b;
            OP_XOR:   res = a ^ b;
            OP_SLL:   res = a << sh;
            OP_SRL:   res = a >> sh;
            OP_SRA:   res = $unsigned($signed(a) >>> sh);
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_NOTA:  res = ~a;
            default:  op_err = 1'b1;
        endcase

`ifdef ALU_PIPE_SAT_EN
        // Overflow direction always follows the sign of a for these four ops
        if (ovf) begin
            res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif

        y                 = res;
        flags             = '0;
        flags[FLAG_ZERO]  = (res == '0);
        flags[FLAG_NEG]   = res[WIDTH-1];
        flags[FLAG_CARRY] = carry;
        flags[FLAG_OVF]   = ovf;
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe -- two-stage valid/ready pipelined ALU.
//   S1 registers the accepted op_code/a/b; S2 evaluates them through
//   alu_pipe_core and registers y/flags/op_err. Latency is two cycles from
//   accept to out_valid; one beat per cycle while out_ready is high.
// Optional feature: define ALU_PIPE_SAT_EN to enable signed saturation
// (handled inside alu_pipe_core).
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous active-high reset
//   in_valid   in   1      operand beat present
//   in_ready   out  1      beat accepted this cycle (combinational from out_ready)
//   op_code    in   4      operation select
//   a, b       in   WIDTH  operands
//   out_valid  out  1      result beat present
//   out_ready  in   1      downstream takes result this cycle
//   y          out  WIDTH  result
//   flags      out  4      {ovf, carry, neg, zero}
//   op_err     out  1      result came from the illegal opcode
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags,
    output logic             op_err
);

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;

    logic [WIDTH-1:0] core_y;
    logic [3:0]       core_flags;
    logic             core_err;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;

    alu_pipe_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .op_code (s1_op),
        .a       (s1_a),
        .b       (s1_b),
        .y       (core_y),
        .flags   (core_flags),
        .op_err  (core_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            flags     <= '0;
            op_err    <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                // bubbles leave the last result in place so y never reflects unaccepted inputs
                if (s1_valid) begin
                    y      <= core_y;
                    flags  <= core_flags;
                    op_err <= core_err;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_op <= op_code;
                s1_a  <= a;
                s1_b  <= b;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- directed self-checking bench for alu_pipe (WIDTH=32).
// Expected values are hand-computed constants; flags are {ovf, carry, neg, zero}.
module tb_alu_pipe;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [3:0]       flags;
    logic             op_err;

    int testCount = 0;
    int failCount = 0;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags),
        .op_err    (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] op, input logic [WIDTH-1:0] va,
                                 input logic [WIDTH-1:0] vb, input logic rdy);
        in_valid  = valid;
        op_code   = op;
        a         = va;
        b         = vb;
        out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat through an empty pipe: accept, check 2-cycle latency, check result, drain
    task automatic sendOne(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] va,
                           input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] expY,
                           input logic [3:0] expFlags, input logic expErr);
        applyStimulus(1'b1, op, va, vb, 1'b1);
        #1;
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, op, va, vb, 1'b1);
        checkOutput({tag, "_lat1_out_valid"}, 64'(out_valid), 64'd0);
        tick();
        checkOutput({tag, "_lat2_out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_y"}, 64'(y), 64'(expY));
        checkOutput({tag, "_flags"}, 64'(flags), 64'(expFlags));
        checkOutput({tag, "_op_err"}, 64'(op_err), 64'(expErr));
        tick();
    endtask

    initial begin
        int txCount;
        int rxCount;
        logic expReady;

        applyStimulus(1'b0, 4'h0, '0, '0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_y", 64'(y), 64'd0);
        checkOutput("rst_flags", 64'(flags), 64'd0);
        checkOutput("rst_op_err", 64'(op_err), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

        sendOne("add_wrap", 4'b0001, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0101, 1'b0);
`ifdef ALU_PIPE_SAT_EN
        sendOne("add_ovf", 4'b0001, 32'h7FFF_FFFF, 32'h1, 32'h7FFF_FFFF, 4'b1000, 1'b0);
        sendOne("inca_ovf", 4'b0101, 32'h7FFF_FFFF, 32'h9, 32'h7FFF_FFFF, 4'b1000, 1'b0);
        sendOne("sub_ovf", 4'b0010, 32'h8000_0000, 32'h1, 32'h8000_0000, 4'b1010, 1'b0);
`else
        sendOne("add_ovf", 4'b0001, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1010, 1'b0);
        sendOne("inca_ovf", 4'b0101, 32'h7FFF_FFFF, 32'h9, 32'h8000_0000, 4'b1010, 1'b0);
        sendOne("sub_ovf", 4'b0010, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b1000, 1'b0);
`endif
        sendOne("sub_borrow", 4'b0010, 32'h3, 32'h5, 32'hFFFF_FFFE, 4'b0110, 1'b0);
        sendOne("deca_zero", 4'b0110, 32'h0, 32'h123, 32'hFFFF_FFFF, 4'b0110, 1'b0);
        sendOne("sra", 4'b1011, 32'h8000_0000, 32'h0000_0104, 32'hF800_0000, 4'b0010, 1'b0);
        sendOne("slt", 4'b1100, 32'hFFFF_FFFF, 32'h0, 32'h1, 4'b0000, 1'b0);
        sendOne("sltu", 4'b1101, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'b0001, 1'b0);
        sendOne("sll_by0", 4'b1001, 32'h1, 32'h20, 32'h1, 4'b0000, 1'b0);
        sendOne("srl", 4'b1010, 32'hF0, 32'h4, 32'hF, 4'b0000, 1'b0);
        sendOne("xor", 4'b1000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 4'b0010, 1'b0);
        sendOne("and", 4'b0011, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 4'b0000, 1'b0);
        sendOne("or", 4'b0100, 32'h1200_0034, 32'h0056_0000, 32'h1256_0034, 4'b0000, 1'b0);
        sendOne("nota", 4'b1110, 32'h0, 32'h5, 32'hFFFF_FFFF, 4'b0010, 1'b0);
        sendOne("passa", 4'b0000, 32'hABCD_0001, 32'h5, 32'hABCD_0001, 4'b0010, 1'b0);
        sendOne("illegal", 4'b1111, 32'h5, 32'h6, 32'h0, 4'b0001, 1'b1);
        sendOne("passb_after_illegal", 4'b0111, 32'h5, 32'h7, 32'h7, 4'b0000, 1'b0);

        // Input changes without in_valid must not reach y
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0001, 32'h1111_0000 + i, 32'h22, 1'b1);
            tick();
            checkOutput("noaccept_out_valid", 64'(out_valid), 64'd0);
            checkOutput("noaccept_y", 64'(y), 64'h7);
        end

        // 8 back-to-back ADD beats (a=3i+1, b=0x10 -> y=3i+17), out_ready low in cycles 3..5
        txCount = 0;
        rxCount = 0;
        for (int c = 0; c < 30 && rxCount < 8; c++) begin
            applyStimulus(txCount < 8, 4'b0001, 32'(3 * txCount + 1), 32'h10, !(c >= 3 && c <= 5));
            #1;
            expReady = !(c >= 3 && c <= 5);
            if (c <= 12) checkOutput($sformatf("b2b_in_ready_c%0d", c), 64'(in_ready), 64'(expReady));
            if (c >= 3 && c <= 5) begin
                checkOutput($sformatf("stall_out_valid_c%0d", c), 64'(out_valid), 64'd1);
                checkOutput($sformatf("stall_y_c%0d", c), 64'(y), 64'd20);
                checkOutput($sformatf("stall_flags_c%0d", c), 64'(flags), 64'd0);
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("b2b_y_beat%0d", rxCount), 64'(y), 64'(3 * rxCount + 17));
                rxCount++;
            end
            if (in_valid && in_ready) txCount++;
            @(posedge clk);
            #1;
        end
        checkOutput("b2b_rx_count", 64'(rxCount), 64'd8);
        applyStimulus(1'b0, 4'h0, '0, '0, 1'b1);
        checkOutput("b2b_drained", 64'(out_valid), 64'd0);

        // Reset with two beats in flight, while in_valid and out_ready are high
        applyStimulus(1'b1, 4'b0001, 32'h40, 32'h1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b0001, 32'h50, 32'h1, 1'b0);
        tick();
        checkOutput("inflight_out_valid", 64'(out_valid), 64'd1);
        applyStimulus(1'b1, 4'b0001, 32'h60, 32'h1, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 4'h0, '0, '0, 1'b1);
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_y", 64'(y), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("post_rst_no_stale", 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
